// File: rtl/tmds_dc_balance.sv
// tmds_dc_balance: two-stage TMDS DC-balancing encoder.
// It turns a transition-minimized 9-bit word into a 10-bit symbol and keeps a running disparity.
module tmds_dc_balance #(
    parameter int CNT_W = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [8:0]              qm_in,
    input  logic                    ve_in,
    input  logic [1:0]              ctrl_in,
    output logic [9:0]              tmds_out,
    output logic signed [CNT_W-1:0] disparity_out
);
    localparam logic signed [CNT_W-1:0] ZERO  = CNT_W'(0);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] LIM   = CNT_W'(10);

    logic [8:0]              qm_q;
    logic [3:0]              n1_q, n1_d;
    logic                    ve_q;
    logic [1:0]              ctrl_q;
    logic [9:0]              tmds_q, tmds_d, ctrl_sym;
    logic signed [CNT_W-1:0] cnt_q, cnt_d, n1_s, diff;
    logic                    pos, neg, case_a, case_b;

    always_comb begin
        n1_d = '0;
        for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b0, qm_in[i]};
    end

    // diff is N1 - N0 = 2*N1 - 8
    always_comb begin
        n1_s     = CNT_W'(n1_q);
        diff     = n1_s + n1_s - EIGHT;
        pos      = !cnt_q[CNT_W-1] && cnt_q != ZERO;
        neg      = cnt_q[CNT_W-1];
        case_a   = cnt_q == ZERO || n1_q == 4'd4;
        case_b   = (pos && n1_q > 4'd4) || (neg && n1_q < 4'd4);
        ctrl_sym = ctrl_q[1] ? (ctrl_q[0] ? 10'h2AB : 10'h154)
                             : (ctrl_q[0] ? 10'h0AB : 10'h354);
        if (!ve_q) begin
            tmds_d = ctrl_sym;
            cnt_d  = ZERO;
        end else if (case_a) begin
            tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? cnt_q + diff : cnt_q - diff;
        end else if (case_b) begin
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q + (qm_q[8] ? TWO : ZERO) - diff;
        end else begin
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + diff - (qm_q[8] ? ZERO : TWO);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            qm_q   <= '0;
            n1_q   <= '0;
            ve_q   <= 1'b0;
            ctrl_q <= 2'b00;
            tmds_q <= 10'h354;
            cnt_q  <= ZERO;
        end else begin
            qm_q   <= qm_in;
            n1_q   <= n1_d;
            ve_q   <= ve_in;
            ctrl_q <= ctrl_in;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    // Legal input streams keep |cnt| <= 10; anything beyond is an upstream bug.
    assert property (@(posedge clk_in) disable iff (!rst_n_in) (cnt_q <= LIM) && (cnt_q >= -LIM));

    assign tmds_out      = tmds_q;
    assign disparity_out = cnt_q;
endmodule

// File: tb/tb_tmds_dc_balance.sv
// tb_tmds_dc_balance: directed scenarios plus randomized pixels checked against a disparity model.
module tb_tmds_dc_balance;
    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic [8:0]        qm_in = '0;
    logic              ve_in = 1'b0;
    logic [1:0]        ctrl_in = 2'b00;
    logic [9:0]        tmds_out;
    logic signed [4:0] disparity_out;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [9:0] CTRL_SYM [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // model: stage-1 contents and running disparity as a plain int
    logic [8:0] s1_qm;
    logic       s1_ve;
    logic [1:0] s1_ctrl;
    int         s1_dat;
    int         m_cnt;
    logic [9:0] m_sym;

    tmds_dc_balance #(.CNT_W(5)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .qm_in(qm_in), .ve_in(ve_in),
        .ctrl_in(ctrl_in), .tmds_out(tmds_out), .disparity_out(disparity_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] tm(input logic [7:0] d);
        logic [8:0] q;
        int         n;
        logic       xn;
        n  = $countones(d);
        xn = n > 4 || (n == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xn;
        return q;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] x, d;
        x    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = x[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        return d;
    endfunction

    // cnt tracks ones-minus-zeros of every symbol sent since the last blanking
    task automatic model_encode();
        int n1, n0;
        n1 = $countones(s1_qm[7:0]);
        n0 = 8 - n1;
        if (!s1_ve) begin
            m_sym = CTRL_SYM[s1_ctrl];
            m_cnt = 0;
        end else begin
            if (m_cnt == 0 || n1 == n0)
                m_sym = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1))
                m_sym = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            else
                m_sym = {1'b0, s1_qm[8], s1_qm[7:0]};
            m_cnt += 2 * $countones(m_sym) - 10;
        end
    endtask

    task automatic model_reset();
        s1_qm = '0; s1_ve = 1'b0; s1_ctrl = 2'b00; s1_dat = -1; m_cnt = 0;
    endtask

    task automatic step(input logic [8:0] q, input logic v, input logic [1:0] c, input int dat);
        qm_in = q; ve_in = v; ctrl_in = c;
        @(posedge clk_in);
        #1;
        model_encode();
        chk("tmds", tmds_out, m_sym);
        chk("cnt", disparity_out, m_cnt);
        if (s1_dat >= 0) chk("decode", decode(tmds_out), s1_dat);
        s1_qm = q; s1_ve = v; s1_ctrl = c; s1_dat = dat;
    endtask

    initial begin
        logic [7:0] d;
        logic       v;
        model_reset();
        #12;
        chk("rst_tmds", tmds_out, 10'h354);
        chk("rst_cnt", disparity_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step(9'h000, 1'b0, 2'b01, -1);
        chk("s1_hold", tmds_out, 10'h354);
        step(9'h1FF, 1'b1, 2'b00, -1);
        chk("s1_ctrl01", tmds_out, 10'h0AB);
        chk("s1_cnt", disparity_out, 0);
        step(9'h1FF, 1'b1, 2'b00, -1);
        chk("s2_a", tmds_out, 10'h1FF);
        chk("s2_a_cnt", disparity_out, 8);
        step(9'h000, 1'b0, 2'b00, -1);
        chk("s2_b", tmds_out, 10'h300);
        chk("s2_b_cnt", disparity_out, 2);
        step(9'h000, 1'b1, 2'b00, -1);
        chk("blank", tmds_out, 10'h354);
        step(9'h10F, 1'b1, 2'b00, -1);
        chk("s3_a", tmds_out, 10'h2FF);
        chk("s3_a_cnt", disparity_out, 8);
        step(9'h000, 1'b0, 2'b10, -1);
        chk("s3_bal", tmds_out, 10'h10F);
        chk("s3_bal_cnt", disparity_out, 8);
        step(9'h1FF, 1'b1, 2'b00, -1);
        chk("s4_pulse", tmds_out, 10'h154);
        chk("s4_clr", disparity_out, 0);
        step(9'h000, 1'b0, 2'b00, -1);
        chk("s4_after", tmds_out, 10'h1FF);
        chk("s4_after_cnt", disparity_out, 8);
        for (int i = 0; i < 10000; i++) begin
            d = 8'($urandom);
            v = $urandom_range(0, 31) != 0;
            step(tm(d), v, 2'($urandom), v ? int'(d) : -1);
            chk("bound", disparity_out <= 10 && disparity_out >= -10, 1);
            if (i == 5000) begin
                #2 rst_n_in = 1'b0;
                #1;
                chk("async_tmds", tmds_out, 10'h354);
                chk("async_cnt", disparity_out, 0);
                @(posedge clk_in);
                #1;
                chk("held_tmds", tmds_out, 10'h354);
                @(negedge clk_in);
                rst_n_in = 1'b1;
                model_reset();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
